rank_sorter_n: RTL

Parametrised, fully pipelined N-input order-statistics sorter with a valid/ready stream interface. It extends the fixed three-input max/mid/min comparator to any input count from 2 to 16, in signed or unsigned mode, with back-pressure and a per-sample run-time rank select. It is the core that the order-statistics filter tops (median, min, max and rank filters over kxk windows) instantiate behind their window buffers.

---
 rtl/rank_sorter_n_if.sv | 28 ++
 rtl/rank_sorter_n.sv | 95 +++++++++
 2 files changed

// File: rtl/rank_sorter_n_if.sv
// Stream bundle for rank_sorter_n: input sample with rank request, sorted output sample.
interface rank_sorter_n_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 9,
  parameter int unsigned RW         = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] din;
  logic                             din_valid;
  logic                             din_ready;
  logic [RW-1:0]                    rank_sel;
  logic                             dout_valid;
  logic                             dout_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] dout_sorted;
  logic [DATA_WIDTH-1:0]            dout_min;
  logic [DATA_WIDTH-1:0]            dout_max;
  logic [DATA_WIDTH-1:0]            dout_mid;
  logic [DATA_WIDTH-1:0]            dout_rank;

  modport master (
    output din, din_valid, rank_sel, dout_ready,
    input  din_ready, dout_valid, dout_sorted, dout_min, dout_max, dout_mid, dout_rank
  );

  modport slave (
    input  din, din_valid, rank_sel, dout_ready,
    output din_ready, dout_valid, dout_sorted, dout_min, dout_max, dout_mid, dout_rank
  );
endinterface

// File: rtl/rank_sorter_n.sv
// N-input order-statistics sorter: registered odd-even transposition network with a
// globally enabled valid/ready pipeline and a per-sample rank select.
module rank_sorter_n #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 9,
  parameter bit          SIGNED     = 1'b0,
  localparam int unsigned RW        = $clog2(NUM_INPUTS)
) (
  input logic              clk,
  input logic              arst,
  rank_sorter_n_if.slave   bus
);
  localparam int unsigned N  = NUM_INPUTS;
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [RW-1:0] RankMax = RW'(N - 1);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("rank_sorter_n: NUM_INPUTS must be in 2..16");
  end

  typedef logic [DW-1:0] elem_t;

  elem_t         data_q [N][N];
  elem_t         data_d [N][N];
  logic [N-1:0]  valid_q, valid_d;
  logic [RW-1:0] rank_q [N];
  logic [RW-1:0] rank_d [N];
  logic          adv;

  function automatic logic gt(input elem_t a, input elem_t b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign adv           = ~valid_q[N-1] | bus.dout_ready;
  assign bus.din_ready = adv;

  always_comb begin
    elem_t tmp;
    tmp = '0;
    for (int s = 0; s < int'(N); s++) begin
      for (int k = 0; k < int'(N); k++) begin
        data_d[s][k] = (s == 0) ? bus.din[k*DW +: DW] : data_q[s-1][k];
      end
      // Stage index s pairs slots starting at the parity of s; strict compare keeps ties.
      for (int j = 0; j < int'(N) - 1; j++) begin
        if ((j % 2) == (s % 2) && gt(data_d[s][j], data_d[s][j+1])) begin
          tmp            = data_d[s][j];
          data_d[s][j]   = data_d[s][j+1];
          data_d[s][j+1] = tmp;
        end
      end
    end
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = bus.din_valid & adv;
    rank_d[0]  = (bus.rank_sel > RankMax) ? RankMax : bus.rank_sel;
    for (int s = 1; s < int'(N); s++) begin
      valid_d[s] = valid_q[s-1];
      rank_d[s]  = rank_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= '0;
      for (int s = 0; s < int'(N); s++) begin
        rank_q[s] <= '0;
        for (int k = 0; k < int'(N); k++) begin
          data_q[s][k] <= '0;
        end
      end
    end else if (adv) begin
      valid_q <= valid_d;
      rank_q  <= rank_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.dout_sorted = '0;
    for (int k = 0; k < int'(N); k++) begin
      bus.dout_sorted[k*DW +: DW] = data_q[N-1][k];
    end
  end

  assign bus.dout_valid = valid_q[N-1];
  assign bus.dout_min   = data_q[N-1][0];
  assign bus.dout_max   = data_q[N-1][N-1];
  assign bus.dout_mid   = data_q[N-1][(N-1)/2];
  assign bus.dout_rank  = data_q[N-1][rank_q[N-1]];
endmodule
